lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised linear-feedback shift register generator: the next generation of the team's fixed 16-bit Galois LFSR. Supports any width W from 4 to 32, Galois or Fibonacci feedback selected at load time, runtime seed loading with zero-seed lock-up protection, and a step enable. It also provides period measurement with a wrap pulse. It sits alongside test-pattern and scrambler logic as the project's pseudo-random source.

## Interface
- W, 16, register width (4..32)
- TAPS_G, 16'hB400, Galois right-shift tap mask; bit W-1 must be set
- TAPS_F, 16'h002D, Fibonacci right-shift tap mask; bit 0 must be set
- SEED, 16'hACE1, reset seed and lock-up replacement seed; must be nonzero
- MODE_RST, LFSR_GALOIS, mode after reset

Ports:
- CLK  in  1  clock; all state changes on its rising edge
- RESET  in  1  synchronous, active-high reset
- EN  in  1  advance one step this cycle
- LOAD  in  1  load SEED_IN and MODE this cycle
- SEED_IN  in  W  seed for LOAD
- MODE  in  1  0 = Galois, 1 = Fibonacci; sampled only on LOAD
- Q  out  W  current register state
- BIT_OUT  out  1  equals Q[0]; serial output
- STEP_CNT  out  W  steps since last reset, load or wrap
- PERIOD  out  W  step count of the last completed period; 0 until the first wrap
- PERIOD_DONE  out  1  one-cycle pulse when Q returns to the start value
- LOCKUP_ERR  out  1  sticky flag: a zero seed was loaded

## Operation
- Priority per cycle: RESET > LOAD > EN > hold.
- **RESET:**
  - Q=SEED, start=SEED, mode=MODE_RST.
  - STEP_CNT=0, PERIOD=0, PERIOD_DONE=0, LOCKUP_ERR=0.
- **LOAD:**
  - mode=MODE, STEP_CNT=0, PERIOD_DONE=0; PERIOD is kept.
  - If SEED_IN≠0: Q=SEED_IN and start=SEED_IN.
  - If SEED_IN=0: Q=SEED, start=SEED, and LOCKUP_ERR is set to 1.
  - EN in the same cycle is ignored; no step occurs.
- **EN step, Galois:** next = (Q>>1) ^ (Q[0] ? TAPS_G : 0).
- **EN step, Fibonacci:**
  - fb = XOR-reduce(Q & TAPS_F).
  - next = {fb, Q[W-1:1]}.
- **Step bookkeeping:**
  - If next == start: STEP_CNT←0, PERIOD←STEP_CNT+1, PERIOD_DONE←1.
  - Otherwise: STEP_CNT←STEP_CNT+1, PERIOD_DONE←0.
- **Width rules:**
  - STEP_CNT arithmetic is W-bit.
  - A maximal-length sequence wraps at 2^W−1 steps, which fits in W bits.
  - For non-maximal taps, STEP_CNT wraps modulo 2^W silently. PERIOD is valid only if the true period is below 2^W.
- Q never becomes 0 while the tap masks meet their constraints; a zero state is unreachable.
- **Hold (EN=0):** all registers keep their values, except PERIOD_DONE, which goes to 0.
- LOCKUP_ERR is cleared only by RESET.

## Timing
- Registered outputs: Q, STEP_CNT, PERIOD, PERIOD_DONE, LOCKUP_ERR.
- BIT_OUT is combinational from Q, with no added logic depth beyond a wire.
- Latency:
  - A step is visible on Q in the cycle after the EN edge.
  - LOAD is visible in the cycle after the LOAD edge.
  - PERIOD_DONE is high in the same cycle Q first shows the start value again, and low on the next cycle unless another wrap occurs.
- Back-to-back EN advances one step per cycle, with no bubbles.
- RESET asserted mid-period abandons the count; PERIOD returns to 0.
- LOAD mid-period: the partial count is discarded and PERIOD keeps its last completed value.

## Structure
- Package lfsr_pkg holds:
  - enum lfsr_mode_t {LFSR_GALOIS=0, LFSR_FIBONACCI=1};
  - default constants LFSR16_TAPS_G=16'hB400, LFSR16_TAPS_F=16'h002D, LFSR16_SEED=16'hACE1.
- Sub-module lfsr_next is purely combinational. It takes Q and mode and returns next, using TAPS_G and TAPS_F as parameters.
- lfsr_gen holds all registers, priority logic and period logic.

## Test plan
- **Reset:** RESET=1 for one cycle at W=16 → Q=16'hACE1, BIT_OUT=1, STEP_CNT=0, PERIOD=0, PERIOD_DONE=0, LOCKUP_ERR=0.
- **Galois step:** after reset, EN=1 for one cycle → Q=16'hE270, STEP_CNT=1.
- **Fibonacci step:** LOAD=1, MODE=1, SEED_IN=16'hACE1, then EN=1 for one cycle → Q=16'h5670, STEP_CNT=1.
- **Full period:** Galois with EN held for 65535 cycles → PERIOD_DONE high only in cycle 65535, Q=16'hACE1, PERIOD=16'hFFFF, STEP_CNT=0. Repeat with W=4, TAPS_G=4'hC, TAPS_F=4'h3, SEED=4'h1 → PERIOD=15 in both modes.
- **Zero seed:** LOAD with SEED_IN=0 → Q=SEED and LOCKUP_ERR=1. LOCKUP_ERR stays 1 through a further nonzero LOAD, and clears only on RESET.
- **Priority:**
  - RESET, LOAD and EN all high → reset values.
  - LOAD and EN high with SEED_IN=16'h1234 → Q=16'h1234 with no step.
  - EN=0 for 10 cycles → Q unchanged.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and default constants for the LFSR generator
// Purpose: feedback mode enum and the 16-bit default taps/seed used as
// parameter defaults by lfsr_next and lfsr_gen.
package lfsr_pkg;

  typedef enum logic {
    LFSR_GALOIS    = 1'b0,
    LFSR_FIBONACCI = 1'b1
  } lfsr_mode_t;

  localparam logic [15:0] LFSR16_TAPS_G = 16'hB400;
  localparam logic [15:0] LFSR16_TAPS_F = 16'h002D;
  localparam logic [15:0] LFSR16_SEED   = 16'hACE1;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational next-state function of the LFSR
// Purpose: computes one right-shift step in Galois or Fibonacci form.
// Ports:
//   q_i    [W-1:0]  current register state
//   mode_i          feedback form to apply
//   next_o [W-1:0]  state after one step
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned    W      = 16,
  parameter logic [W-1:0]   TAPS_G = W'(LFSR16_TAPS_G),
  parameter logic [W-1:0]   TAPS_F = W'(LFSR16_TAPS_F)
) (
  input  logic [W-1:0] q_i,
  input  lfsr_mode_t   mode_i,
  output logic [W-1:0] next_o
);

  always_comb begin
    next_o = '0;
    if (mode_i == LFSR_GALOIS) begin
      // Bit shifted out of the bottom is folded back in at every tap.
      next_o = (q_i >> 1) ^ (q_i[0] ? TAPS_G : '0);
    end else begin
      // Parity of the tapped bits enters at the top.
      next_o = {^(q_i & TAPS_F), q_i[W-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised LFSR generator with seed load and period measurement
// Purpose: pseudo-random source with Galois/Fibonacci feedback, zero-seed
// protection, step counting and a wrap pulse when the start value recurs.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   en_i                   advance one step
//   load_i                 load seed_in_i / mode_i (wins over en_i)
//   seed_in_i [W-1:0]      seed for load; zero is replaced by SEED
//   mode_i                 0 = Galois, 1 = Fibonacci, sampled on load
//   q_o [W-1:0]            register state
//   bit_out_o              serial output, q_o[0]
//   step_cnt_o [W-1:0]     steps since reset, load or wrap
//   period_o [W-1:0]       length of the last completed period
//   period_done_o          one-cycle pulse on wrap
//   lockup_err_o           sticky: a zero seed was loaded
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned    W        = 16,
  parameter logic [W-1:0]   TAPS_G   = W'(LFSR16_TAPS_G),
  parameter logic [W-1:0]   TAPS_F   = W'(LFSR16_TAPS_F),
  parameter logic [W-1:0]   SEED     = W'(LFSR16_SEED),
  parameter lfsr_mode_t     MODE_RST = LFSR_GALOIS
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_in_i,
  input  logic         mode_i,
  output logic [W-1:0] q_o,
  output logic         bit_out_o,
  output logic [W-1:0] step_cnt_o,
  output logic [W-1:0] period_o,
  output logic         period_done_o,
  output logic         lockup_err_o
);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] start_q, start_d;
  lfsr_mode_t   mode_q, mode_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] period_q, period_d;
  logic         pd_q, pd_d;
  logic         lock_q, lock_d;
  logic [W-1:0] next_q;

  lfsr_next #(
    .W      (W),
    .TAPS_G (TAPS_G),
    .TAPS_F (TAPS_F)
  ) u_next (
    .q_i    (q_q),
    .mode_i (mode_q),
    .next_o (next_q)
  );

  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    mode_d   = mode_q;
    step_d   = step_q;
    period_d = period_q;
    pd_d     = 1'b0;
    lock_d   = lock_q;
    if (load_i) begin
      mode_d = lfsr_mode_t'(mode_i);
      step_d = '0;
      if (seed_in_i != '0) begin
        q_d     = seed_in_i;
        start_d = seed_in_i;
      end else begin
        // A zero seed would lock the register at zero forever.
        q_d     = SEED;
        start_d = SEED;
        lock_d  = 1'b1;
      end
    end else if (en_i) begin
      q_d = next_q;
      if (next_q == start_q) begin
        step_d   = '0;
        period_d = step_q + W'(1);
        pd_d     = 1'b1;
      end else begin
        step_d = step_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q      <= SEED;
      start_q  <= SEED;
      mode_q   <= MODE_RST;
      step_q   <= '0;
      period_q <= '0;
      pd_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      period_q <= period_d;
      pd_q     <= pd_d;
      lock_q   <= lock_d;
    end
  end

  assign q_o           = q_q;
  assign bit_out_o     = q_q[0];
  assign step_cnt_o    = step_q;
  assign period_o      = period_q;
  assign period_done_o = pd_q;
  assign lockup_err_o  = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard testbench for lfsr_gen at W=16 and W=4
module tb_lfsr_gen;
  import lfsr_pkg::*;

  localparam logic [4:0] M_Q = 5'd1, M_STEP = 5'd2, M_PER = 5'd4, M_PD = 5'd8, M_LOCK = 5'd16;
  localparam logic [4:0] M_ALL = 5'd31;

  typedef struct {
    int          due;
    int          id;
    logic        sel;
    logic [4:0]  mask;
    logic [15:0] q;
    logic [15:0] step;
    logic [15:0] per;
    logic        pd;
    logic        lock;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst16 = 1'b0, load16 = 1'b0, en16 = 1'b0, mode16 = 1'b0;
  logic [15:0] seed16 = '0;
  logic [15:0] q16, step16, per16;
  logic        bit16, pd16, lock16;

  logic        rst4 = 1'b0, load4 = 1'b0, en4 = 1'b0, mode4 = 1'b0;
  logic [3:0]  seed4 = '0;
  logic [3:0]  q4, step4, per4;
  logic        bit4, pd4, lock4;

  lfsr_gen #(.W(16)) dut16 (
    .clk_i(clk), .reset_i(rst16), .en_i(en16), .load_i(load16),
    .seed_in_i(seed16), .mode_i(mode16), .q_o(q16), .bit_out_o(bit16),
    .step_cnt_o(step16), .period_o(per16), .period_done_o(pd16), .lockup_err_o(lock16)
  );

  lfsr_gen #(.W(4), .TAPS_G(4'hC), .TAPS_F(4'h3), .SEED(4'h1), .MODE_RST(LFSR_GALOIS)) dut4 (
    .clk_i(clk), .reset_i(rst4), .en_i(en4), .load_i(load4),
    .seed_in_i(seed4), .mode_i(mode4), .q_o(q4), .bit_out_o(bit4),
    .step_cnt_o(step4), .period_o(per4), .period_done_o(pd4), .lockup_err_o(lock4)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] gtab [0:14] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                             4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] ftab [0:14] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                             4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

  function automatic exp_t mk(input int id, input logic [4:0] mask, input logic [15:0] q,
                              input logic [15:0] step, input logic [15:0] per,
                              input logic pd, input logic lock);
    exp_t e;
    e.due = 0; e.id = id; e.sel = 1'b0; e.mask = mask;
    e.q = q; e.step = step; e.per = per; e.pd = pd; e.lock = lock;
    return e;
  endfunction

  task automatic drive(input logic sel, input logic r, input logic l, input logic e,
                       input logic m, input logic [15:0] s, input exp_t ex);
    @(negedge clk);
    rst16 = 1'b0; load16 = 1'b0; en16 = 1'b0; mode16 = 1'b0; seed16 = '0;
    rst4  = 1'b0; load4  = 1'b0; en4  = 1'b0; mode4  = 1'b0; seed4  = '0;
    if (sel) begin
      rst4 = r; load4 = l; en4 = e; mode4 = m; seed4 = s[3:0];
    end else begin
      rst16 = r; load16 = l; en16 = e; mode16 = m; seed16 = s;
    end
    ex.due = cyc + 1;
    ex.sel = sel;
    sb.push_back(ex);
  endtask

  task automatic cmp(input int id, input string f, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL id%0d %s actual=%h required=%h", id, f, act, req);
    end
  endtask

  exp_t ce;
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ce = sb.pop_front();
      if (ce.mask[0]) begin
        cmp(ce.id, "q", ce.sel ? {12'b0, q4} : q16, ce.q);
        cmp(ce.id, "bit_out", {15'b0, ce.sel ? bit4 : bit16}, {15'b0, ce.q[0]});
      end
      if (ce.mask[1]) cmp(ce.id, "step_cnt", ce.sel ? {12'b0, step4} : step16, ce.step);
      if (ce.mask[2]) cmp(ce.id, "period", ce.sel ? {12'b0, per4} : per16, ce.per);
      if (ce.mask[3]) cmp(ce.id, "period_done", {15'b0, ce.sel ? pd4 : pd16}, {15'b0, ce.pd});
      if (ce.mask[4]) cmp(ce.id, "lockup_err", {15'b0, ce.sel ? lock4 : lock16}, {15'b0, ce.lock});
    end
  end

  initial begin
    // W=16 directed vectors (sel 0)
    drive(0, 1, 0, 0, 0, 16'h0000, mk(1, M_ALL, 16'hACE1, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 0, 16'h0000, mk(2, M_ALL, 16'hE270, 1, 0, 0, 0));
    drive(0, 0, 1, 0, 1, 16'hACE1, mk(3, M_ALL, 16'hACE1, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 0, 16'h0000, mk(4, M_ALL, 16'h5670, 1, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      drive(0, 0, 0, 0, 0, 16'h0000, mk(5, M_ALL, 16'h5670, 1, 0, 0, 0));
    drive(0, 0, 1, 1, 0, 16'h1234, mk(6, M_ALL, 16'h1234, 0, 0, 0, 0));
    drive(0, 0, 1, 0, 0, 16'h0000, mk(7, M_ALL, 16'hACE1, 0, 0, 0, 1));
    drive(0, 0, 1, 0, 0, 16'h1234, mk(8, M_ALL, 16'h1234, 0, 0, 0, 1));
    drive(0, 1, 1, 1, 1, 16'h1234, mk(9, M_ALL, 16'hACE1, 0, 0, 0, 0));
    // Full Galois period from ACE1
    for (int i = 1; i <= 65535; i++) begin
      if (i < 65535)
        drive(0, 0, 0, 1, 0, 16'h0000, mk(10, M_STEP | M_PER | M_PD, 0, i[15:0], 0, 0, 0));
      else
        drive(0, 0, 0, 1, 0, 16'h0000, mk(11, M_ALL, 16'hACE1, 0, 16'hFFFF, 1, 0));
    end
    drive(0, 0, 0, 0, 0, 16'h0000, mk(12, M_ALL, 16'hACE1, 0, 16'hFFFF, 0, 0));
    for (int i = 1; i <= 3; i++)
      drive(0, 0, 0, 1, 0, 16'h0000, mk(13, M_STEP | M_PER | M_PD, 0, i[15:0], 16'hFFFF, 0, 0));
    drive(0, 0, 1, 0, 0, 16'h1234, mk(14, M_ALL, 16'h1234, 0, 16'hFFFF, 0, 0));
    drive(0, 1, 0, 1, 0, 16'h0000, mk(15, M_ALL, 16'hACE1, 0, 0, 0, 0));

    // W=4 Galois then Fibonacci full periods (sel 1)
    drive(1, 1, 0, 0, 0, 16'h0000, mk(20, M_ALL, 16'h1, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) begin
      if (i < 14)
        drive(1, 0, 0, 1, 0, 16'h0000, mk(21, M_ALL, {12'b0, gtab[i]}, 16'(i + 1), 0, 0, 0));
      else
        drive(1, 0, 0, 1, 0, 16'h0000, mk(22, M_ALL, {12'b0, gtab[i]}, 0, 16'd15, 1, 0));
    end
    drive(1, 0, 1, 0, 1, 16'h0001, mk(23, M_ALL, 16'h1, 0, 16'd15, 0, 0));
    for (int i = 0; i < 15; i++) begin
      if (i < 14)
        drive(1, 0, 0, 1, 0, 16'h0000, mk(24, M_ALL, {12'b0, ftab[i]}, 16'(i + 1), 16'd15, 0, 0));
      else
        drive(1, 0, 0, 1, 0, 16'h0000, mk(25, M_ALL, {12'b0, ftab[i]}, 0, 16'd15, 1, 0));
    end
    drive(1, 0, 0, 0, 0, 16'h0000, mk(26, M_ALL, 16'h1, 0, 16'd15, 0, 0));

    @(negedge clk);
    rst4 = 1'b0; en4 = 1'b0; load4 = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
